// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, fill FSM states and word-address helper
package cache_pkg;

  localparam int CACHE_ADDR_W    = 16;
  localparam int CACHE_DATA_W    = 16;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
  localparam int BASE_W          = CACHE_ADDR_W - $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

  // Byte address of a 16-bit word inside a block: {block base, word index, 0}.
  function automatic logic [CACHE_ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                       input logic [OFF_W-1:0]  word);
    return {base, word, 1'b0};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - saturating OFF_W+1-bit word counter with sync clear and done flag
module fill_counter
  import cache_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [OFF_W:0] cnt_o,
  output logic           done_o
);

  logic [OFF_W:0] cnt_q, cnt_d;

  // Block size is a power of two, so the top bit marks a full block.
  assign done_o = cnt_q[OFF_W];
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - data-cache miss handler: block fetch, data-array fill, tag install
// Optional critical-word-first ordering: CACHE_FILL_CRITICAL_WORD_FIRST_EN
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_array_address,
  output logic [DATA_W-1:0] data_array_data,
  output logic              write_tag_array,
  output logic              fill_done
);

  fill_state_t       state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  start_q, start_d;
  logic [OFF_W-1:0]  start_sel;
  logic [OFF_W:0]    issue_cnt, recv_cnt;
  logic              issue_done, recv_done;
  logic              in_fill, accept;
  logic [OFF_W-1:0]  issue_word, recv_word;
  logic              unused_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_sel   = miss_address[OFF_W:1];
  assign unused_bits = ^{miss_address[0], issue_cnt[OFF_W], recv_cnt[OFF_W]};
`else
  assign start_sel   = '0;
  assign unused_bits = ^{miss_address[OFF_W:0], issue_cnt[OFF_W], recv_cnt[OFF_W]};
`endif

  assign in_fill = (state_q == FILL);
  // Returns outside FILL or past the last word are dropped without a write.
  assign accept  = in_fill && memory_data_valid && !recv_done;

  fill_counter u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_fill),
    .en_i   (in_fill),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  fill_counter u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_fill),
    .en_i   (accept),
    .cnt_o  (recv_cnt),
    .done_o (recv_done)
  );

  assign issue_word = issue_cnt[OFF_W-1:0] + start_q;
  assign recv_word  = recv_cnt[OFF_W-1:0] + start_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
          base_d  = miss_address[ADDR_W-1:OFF_W+1];
          start_d = start_sel;
        end
      end
      FILL: begin
        if (accept && (recv_cnt[OFF_W-1:0] == OFF_W'(WORDS_PER_BLOCK - 1))) begin
          state_d = TAG;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
    end
  end

  assign fsm_busy           = (state_q != IDLE);
  assign memory_req         = in_fill && !issue_done;
  assign memory_address     = word_addr(base_q, issue_word);
  assign write_data_array   = accept;
  assign data_array_address = word_addr(base_q, recv_word);
  assign data_array_data    = accept ? memory_data : '0;
  assign write_tag_array    = (state_q == TAG);
  assign fill_done          = (state_q == TAG);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized bench for cache_fill_fsm against a block-order reference model
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, memory_req, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, data_array_address, data_array_data;

  cache_fill_fsm dut (
    .clk                (clk),
    .rst                (rst),
    .miss_detected      (miss_detected),
    .miss_address       (miss_address),
    .memory_data        (memory_data),
    .memory_data_valid  (memory_data_valid),
    .fsm_busy           (fsm_busy),
    .memory_req         (memory_req),
    .memory_address     (memory_address),
    .write_data_array   (write_data_array),
    .data_array_address (data_array_address),
    .data_array_data    (data_array_data),
    .write_tag_array    (write_tag_array),
    .fill_done          (fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 4;
  int          busy_cnt = 0;
  bit          inject = 1'b0;
  mem_t        sched[$];
  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          tag_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected byte address of the k-th word moved for a miss at 'miss'.
  function automatic logic [15:0] exp_addr(input logic [15:0] miss, input int k);
    int start;
    start = CWF ? int'(miss[3:1]) : 0;
    return 16'(int'(miss & 16'hFFF0) + 2 * ((start + k) % 8));
  endfunction

  // Memory model (fixed latency, in order) and output monitor.
  initial begin
    mem_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (memory_req) begin
          req_log.push_back(memory_address);
          req_cyc.push_back(cyc);
          e.due  = cyc + lat;
          e.data = 16'($urandom);
          sched.push_back(e);
        end
        if (write_data_array) begin
          wr_log.push_back(data_array_address);
          wr_cyc.push_back(cyc);
          check("wr_has_valid", memory_data_valid, 1);
          check("wr_data", data_array_data, memory_data);
        end
        if (write_tag_array) begin
          tag_cyc.push_back(cyc);
          check("tag_done_pulse", fill_done, 1);
          check("tag_quiet", {memory_req, write_data_array}, 0);
        end
        if (fsm_busy) busy_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        sched.delete();
        memory_data_valid = 1'b0;
      end else if (inject) begin
        memory_data_valid = 1'b1;
        memory_data       = 16'hDEAD;
      end else if (sched.size() > 0 && sched[0].due == cyc) begin
        memory_data_valid = 1'b1;
        memory_data       = sched[0].data;
        void'(sched.pop_front());
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
      end
    end
  end

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete();
    wr_log.delete();  wr_cyc.delete();
    tag_cyc.delete(); busy_cnt = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, fsm_busy, 0);
    check({tag, "_req"}, memory_req, 0);
    check({tag, "_wda"}, write_data_array, 0);
    check({tag, "_tag"}, {write_tag_array, fill_done}, 0);
    check({tag, "_maddr"}, memory_address, 0);
    check({tag, "_daddr"}, data_array_address, 0);
    check({tag, "_ddata"}, data_array_data, 0);
  endtask

  // One block starting in cycle c0; its entries begin at index 'off' of the logs.
  task automatic verify_fill(input logic [15:0] addr, input int c0, input int off);
    if (req_log.size() < off + 8 || wr_log.size() < off + 8 || tag_cyc.size() < off / 8 + 1) begin
      check("log_short", 0, 1);
    end else begin
      for (int k = 0; k < 8; k++) begin
        check("req_addr", req_log[off+k], exp_addr(addr, k));
        check("req_cycle", req_cyc[off+k], c0 + k);
        check("wr_addr", wr_log[off+k], exp_addr(addr, k));
        check("wr_cycle", wr_cyc[off+k], c0 + k + lat);
      end
      check("tag_cycle", tag_cyc[off/8], c0 + 8 + lat);
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input int l, input bit midmiss);
    int mc, t;
    clear_logs();
    lat = l;
    @(posedge clk); #2;
    miss_address  = addr;
    miss_detected = 1'b1;
    mc = cyc;
    @(posedge clk); #2;
    miss_detected = 1'b0;
    if (midmiss) begin
      repeat (3) @(posedge clk);
      #2;
      miss_address  = 16'hABC0;
      miss_detected = 1'b1;
      @(posedge clk); #2;
      miss_detected = 1'b0;
    end
    t = 0;
    while (tag_cyc.size() == 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("fill_timeout", tag_cyc.size() > 0, 1);
    repeat (3) @(posedge clk);
    #2;
    verify_fill(addr, mc + 1, 0);
    check("n_req", req_log.size(), 8);
    check("n_wr", wr_log.size(), 8);
    check("n_tag", tag_cyc.size(), 1);
    check("busy_cycles", busy_cnt, 9 + lat);
    check("idle_after", fsm_busy, 0);
  endtask

  initial begin
    int t, mc;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    run_fill(16'h1236, 4, 1'b0);
    run_fill(16'h1236, 4, 1'b1);

    // Stray return while idle must not write or advance the counters.
    clear_logs();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk); #1;
    check("idle_valid_wda", write_data_array, 0);
    check("idle_valid_busy", fsm_busy, 0);
    inject = 1'b0;
    run_fill(16'h5670, 3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_fill(16'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end

    // Reset on the 5th received word aborts the fill without a tag write.
    clear_logs();
    lat = 3;
    @(posedge clk); #2;
    miss_address  = 16'h1236;
    miss_detected = 1'b1;
    @(posedge clk); #2;
    miss_detected = 1'b0;
    t = 0;
    while (wr_log.size() < 5 && t < 100) begin
      @(negedge clk); #2;
      t++;
    end
    check("rst_wait_timeout", wr_log.size(), 5);
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("rst_no_tag", tag_cyc.size(), 0);
    check("rst_no_more_wr", wr_log.size(), 5);
    run_fill(16'h0040, 2, 1'b0);

    // Back-to-back misses with the second request held high.
    clear_logs();
    lat = 5;
    @(posedge clk); #2;
    miss_address  = 16'h1000;
    miss_detected = 1'b1;
    mc = cyc;
    @(posedge clk); #2;
    miss_address = 16'h2000;
    t = 0;
    while (req_log.size() <= 8 && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    miss_detected = 1'b0;
    t = 0;
    while (tag_cyc.size() < 2 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #2;
    check("b2b_n_wr", wr_log.size(), 16);
    check("b2b_n_tag", tag_cyc.size(), 2);
    check("b2b_n_req", req_log.size(), 16);
    verify_fill(16'h1000, mc + 1, 0);
    verify_fill(16'h2000, mc + 1 + 8 + lat + 2, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
